// File: rtl/primitive_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : primitive_assembler_pkg
// Purpose  : Primitive type codes, assembler FSM encoding, vertex-count helper
// Revision : 1.0 - initial release
// ============================================================================
package primitive_assembler_pkg;

  localparam logic [1:0] PRIM_POINT = 2'd0;
  localparam logic [1:0] PRIM_LINE  = 2'd1;
  localparam logic [1:0] PRIM_TRI   = 2'd2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  function automatic logic [1:0] verts_per_prim(input logic [1:0] prim_type);
    case (prim_type)
      PRIM_POINT: verts_per_prim = 2'd1;
      PRIM_LINE:  verts_per_prim = 2'd2;
      default:    verts_per_prim = 2'd3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/primitive_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : primitive_assembler_if
// Purpose  : Decode-side strobes and raster-side valid/ready stream
// Revision : 1.0 - initial release
// ============================================================================
interface primitive_assembler_if #(
  parameter int VTX_W  = 32,
  parameter int ADDR_W = 3
);
  logic              StartPrimitive;
  logic [3:0]        PrimitiveType;
  logic              VertexValid;
  logic [VTX_W-1:0]  Vertex;
  logic              EndPrimitive;
  logic              Draw;
  logic              OutValid;
  logic              OutReady;
  logic [1:0]        OutType;
  logic [VTX_W-1:0]  OutV0;
  logic [VTX_W-1:0]  OutV1;
  logic [VTX_W-1:0]  OutV2;
  logic [ADDR_W:0]   PrimCount;
  logic              Busy;
  logic              Overflow;
  logic              ProtocolErr;

  modport master (
    output StartPrimitive, PrimitiveType, VertexValid, Vertex, EndPrimitive, Draw, OutReady,
    input  OutValid, OutType, OutV0, OutV1, OutV2, PrimCount, Busy, Overflow, ProtocolErr
  );

  modport slave (
    input  StartPrimitive, PrimitiveType, VertexValid, Vertex, EndPrimitive, Draw, OutReady,
    output OutValid, OutType, OutV0, OutV1, OutV2, PrimCount, Busy, Overflow, ProtocolErr
  );
endinterface
`default_nettype wire

// File: rtl/primitive_assembler_fifo.sv
`default_nettype none
// ============================================================================
// Module   : primitive_assembler_fifo
// Purpose  : Primitive FIFO with a release pointer gating what the reader sees
// Revision : 1.0 - initial release
// ============================================================================
module primitive_assembler_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int VTX_W  = 32
) (
  input  wire logic              CLK,
  input  wire logic              RESET,
  input  wire logic              push,
  input  wire logic [1:0]        push_type,
  input  wire logic [VTX_W-1:0]  push_v0,
  input  wire logic [VTX_W-1:0]  push_v1,
  input  wire logic [VTX_W-1:0]  push_v2,
  input  wire logic              draw,
  input  wire logic              pop_ready,
  output logic                   out_valid,
  output logic [1:0]             out_type,
  output logic [VTX_W-1:0]       out_v0,
  output logic [VTX_W-1:0]       out_v1,
  output logic [VTX_W-1:0]       out_v2,
  output logic [ADDR_W:0]        count,
  output logic                   drop
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]       r_type_mem [DEPTH];
  logic [VTX_W-1:0] r_v0_mem   [DEPTH];
  logic [VTX_W-1:0] r_v1_mem   [DEPTH];
  logic [VTX_W-1:0] r_v2_mem   [DEPTH];

  logic [ADDR_W:0] r_wr;
  logic [ADDR_W:0] r_rel;
  logic [ADDR_W:0] r_rd;
  logic [ADDR_W:0] w_wr_next;
  logic            w_pop;
  logic            w_push_ok;

  assign count     = r_wr - r_rd;
  assign out_valid = (r_rd != r_rel);
  assign w_pop     = out_valid && pop_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = push && ((count < C_DEPTH) || w_pop);
  assign drop      = push && !w_push_ok;
  assign w_wr_next = w_push_ok ? (r_wr + C_ONE) : r_wr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr  <= '0;
      r_rel <= '0;
      r_rd  <= '0;
    end else begin
      r_wr <= w_wr_next;
      if (draw)
        r_rel <= w_wr_next;
      if (w_pop)
        r_rd <= r_rd + C_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_type_mem[r_wr[ADDR_W-1:0]] <= push_type;
      r_v0_mem[r_wr[ADDR_W-1:0]]   <= push_v0;
      r_v1_mem[r_wr[ADDR_W-1:0]]   <= push_v1;
      r_v2_mem[r_wr[ADDR_W-1:0]]   <= push_v2;
    end
  end

  // Storage is not reset, so the read port is masked whenever nothing is offered.
  assign out_type = out_valid ? r_type_mem[r_rd[ADDR_W-1:0]] : 2'd0;
  assign out_v0   = out_valid ? r_v0_mem[r_rd[ADDR_W-1:0]]   : '0;
  assign out_v1   = out_valid ? r_v1_mem[r_rd[ADDR_W-1:0]]   : '0;
  assign out_v2   = out_valid ? r_v2_mem[r_rd[ADDR_W-1:0]]   : '0;

endmodule
`default_nettype wire

// File: rtl/primitive_assembler.sv
`default_nettype none
// ============================================================================
// Module   : primitive_assembler
// Purpose  : Groups decoded vertices into primitives, buffers them until Draw
// Revision : 1.0 - initial release
// ============================================================================
module primitive_assembler
  import primitive_assembler_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int VTX_W  = 32
) (
  input  wire logic            CLK,
  input  wire logic            RESET,
  primitive_assembler_if.slave bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_vidx;
  logic [1:0]       r_type;
  logic [VTX_W-1:0] r_s0;
  logic [VTX_W-1:0] r_s1;
  logic             r_overflow;
  logic             r_proto_err;

  logic             w_type_ok;
  logic             w_vtx_take;
  logic             w_vtx_stray;
  logic             w_complete;
  logic             w_proto_set;
  logic             w_drop;
  logic [VTX_W-1:0] w_pv0;
  logic [VTX_W-1:0] w_pv1;
  logic [VTX_W-1:0] w_pv2;

  assign w_type_ok = (bus.PrimitiveType <= 4'd2);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.StartPrimitive)
      w_state_next = w_type_ok ? COLLECT : IDLE;
    else if (bus.EndPrimitive)
      w_state_next = IDLE;
  end

  // Start and End both outrank a vertex arriving in the same cycle.
  always_comb begin
    w_vtx_take  = bus.VertexValid && !bus.StartPrimitive && !bus.EndPrimitive
                  && (r_state == COLLECT);
    w_vtx_stray = bus.VertexValid && !bus.StartPrimitive && !bus.EndPrimitive
                  && (r_state == IDLE);
    w_complete  = w_vtx_take && ((r_vidx + 2'd1) == verts_per_prim(r_type));
    w_proto_set = (bus.StartPrimitive && !w_type_ok) || w_vtx_stray;
    w_pv0 = '0;
    w_pv1 = '0;
    w_pv2 = '0;
    case (r_type)
      PRIM_POINT: w_pv0 = bus.Vertex;
      PRIM_LINE: begin
        w_pv0 = r_s0;
        w_pv1 = bus.Vertex;
      end
      default: begin
        w_pv0 = r_s0;
        w_pv1 = r_s1;
        w_pv2 = bus.Vertex;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_vidx      <= 2'd0;
      r_type      <= PRIM_POINT;
      r_s0        <= '0;
      r_s1        <= '0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (bus.StartPrimitive) begin
        r_vidx <= 2'd0;
        if (w_type_ok)
          r_type <= bus.PrimitiveType[1:0];
      end else if (bus.EndPrimitive) begin
        r_vidx <= 2'd0;
      end else if (w_vtx_take) begin
        if (w_complete) begin
          r_vidx <= 2'd0;
        end else begin
          if (r_vidx == 2'd0)
            r_s0 <= bus.Vertex;
          else
            r_s1 <= bus.Vertex;
          r_vidx <= r_vidx + 2'd1;
        end
      end
      r_overflow  <= r_overflow  | w_drop;
      r_proto_err <= r_proto_err | w_proto_set;
    end
  end

  primitive_assembler_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .VTX_W  (VTX_W)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (w_complete),
    .push_type (r_type),
    .push_v0   (w_pv0),
    .push_v1   (w_pv1),
    .push_v2   (w_pv2),
    .draw      (bus.Draw),
    .pop_ready (bus.OutReady),
    .out_valid (bus.OutValid),
    .out_type  (bus.OutType),
    .out_v0    (bus.OutV0),
    .out_v1    (bus.OutV1),
    .out_v2    (bus.OutV2),
    .count     (bus.PrimCount),
    .drop      (w_drop)
  );

  assign bus.Busy        = (r_state == COLLECT);
  assign bus.Overflow    = r_overflow;
  assign bus.ProtocolErr = r_proto_err;

endmodule
`default_nettype wire
